bcd_time_counter: RTL and testbench
===================================

# bcd_time_counter

- Free-running 24-hour BCD timekeeper for the digital clock.
- Produces the hour/minute digits (`out_Hh`, `out_Hl`, `out_mh`, `out_ml`) that the alarm comparator reads.
- Also drives the display seconds digits.
- Two push buttons set the time in a set mode.
- Sits between the board oscillator/buttons and the alarm-compare and display logic.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per second; the prescaler terminal count is `CLK_HZ-1`.
- `DEBOUNCE_CYC`, default 1_000_000: cycles a synchronized button level must stay stable to be accepted.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `set_mode`  in  1  level input, already synchronous.
  - 1: timekeeping paused, buttons edit the time.
  - 0: normal run.
- `btn_h`  in  1  raw hour-advance button, asynchronous and bouncing.
- `btn_m`  in  1  raw minute-advance button, asynchronous and bouncing.
- `out_Hh`  out  4  hours tens, 0–2.
- `out_Hl`  out  4  hours units, 0–9 (0–3 when `out_Hh`=2).
- `out_mh`  out  4  minutes tens, 0–5.
- `out_ml`  out  4  minutes units, 0–9.
- `out_sh`  out  4  seconds tens, 0–5.
- `out_sl`  out  4  seconds units, 0–9.
- `sec_tick`  out  1  one-cycle pulse, same cycle the seconds digits change.
- `min_tick`  out  1  one-cycle pulse, same cycle the minute digits change, from rollover or from a button.

## Operation
- Reset: all six digits 0 (00:00:00); `sec_tick`=`min_tick`=0; prescaler 0; debouncers report released.
- Prescaler:
  - Counts 0..`CLK_HZ-1` while `set_mode`=0.
  - At terminal count it issues an internal `tick` and wraps to 0.
  - While `set_mode`=1 it is held at 0.
- On `tick`, seconds advance in BCD:
  - `sl` 9→0 with `sh`+1.
  - `sh:sl` 59→00 carries to minutes.
- Minute carry uses the same BCD rule: `mh:ml` 59→00 carries to hours.
- Hours:
  - `Hl` 9→0 with `Hh`+1.
  - `Hh:Hl` 23→00; never 24.
- Cascade:
  - All carries resolve in one clock edge.
  - 23:59:59 + tick → 00:00:00 in a single update.
- Buttons:
  - Each passes a 2-flop synchronizer, then a stability counter.
  - The debounced rising edge yields a one-cycle press pulse.
- Set mode:
  - On the first cycle `set_mode` is seen high, seconds clear to 00.
  - `btn_m` press: minutes +1 mod 60, no carry into hours.
  - `btn_h` press: hours +1 mod 24.
  - Both presses in the same cycle: both fields advance independently.
  - Presses while `set_mode`=0 are discarded.
- Leaving set mode: the prescaler starts from 0, so the first second after release is a full `CLK_HZ` cycles.
- Digits never hold a non-BCD or out-of-range value. Any illegal state (not reachable from reset) returns to 0 for that field on its next update.

## Timing
- Digits and ticks are registered outputs.
- A `tick` at prescaler count `CLK_HZ-1` in cycle N gives new digits and a `sec_tick` pulse visible after edge N+1.
- `min_tick` is asserted in the same cycle as `sec_tick` when seconds wrap 59→00.
- Button latency from a clean raw edge to the digit change: 2 (sync) + `DEBOUNCE_CYC` + 1 cycles.
- A bounce shorter than `DEBOUNCE_CYC` produces no press.
- Holding a button produces exactly one press; auto-repeat is not provided.
- `rst_n` assertion mid-count clears everything immediately, without waiting for a clock edge.
- Deassertion is synchronized externally; counting resumes on the first edge after release.
- `set_mode` is sampled every cycle. A `tick` and a `set_mode` rise in the same cycle: set mode wins, the tick is dropped, and seconds clear.

## Structure
- Shared package `clock_pkg` holds:
  - Digit limits: `SEC_MAX`=59, `MIN_MAX`=59, `HOUR_MAX`=23.
  - The 4-bit BCD digit typedef.
  - `CLK_HZ` default, shared with the alarm and display blocks.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYC`; ports `clk`, `rst_n`, `raw`, `press`), instantiated twice.
- The prescaler and BCD cascade stay in `bcd_time_counter`.

## Test plan
All scenarios use `CLK_HZ`=4 and `DEBOUNCE_CYC`=3.
- Reset, run 4 cycles → digits 00:00:01, `sec_tick` high exactly 1 cycle.
- Preload to 23:59:58 via buttons, run 8 cycles:
  - Ticks give 23:59:59, then 00:00:00.
  - `min_tick` and `sec_tick` are coincident at the wrap.
- `set_mode`=1 at 12:34:56, pulse `btn_m` clean 6 cycles high:
  - Seconds read 00, time reads 12:35.
  - 26 `btn_m` presses from :34 → minutes wrap to 00, hours stay 12.
- `btn_h` with 2-cycle bounces then a 5-cycle stable high → exactly one hour increment; 23 → 00.
- In set mode, `btn_h` and `btn_m` presses align on the same cycle at 09:59 → 10:00, both changing on one edge.
- Assert `rst_n`=0 mid-prescale at 17:45:30:
  - Outputs read 00:00:00 before the next clock edge.
  - After release, the first `sec_tick` comes after 4 cycles.

Source files
------------

// File: rtl/clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : clock_pkg                                              |
// | Description : Shared digit limits, BCD digit type and BCD increment  |
// |               helper for the digital clock blocks.                   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package clock_pkg;

    // One BCD digit
    typedef logic [3:0] bcd_t;

    // Two-digit BCD field plus carry-out of its increment
    typedef struct packed {
        logic carry;
        bcd_t hi;
        bcd_t lo;
    } bcd_pair_t;

    localparam int SEC_MAX        = 59;
    localparam int MIN_MAX        = 59;
    localparam int HOUR_MAX       = 23;
    localparam int CLK_HZ_DEFAULT = 50_000_000;

    // Increment a two-digit BCD field that wraps after max_val.
    // An out-of-range or non-BCD field goes to 00 without a carry.
    function automatic bcd_pair_t bcd_inc(input bcd_t hi, input bcd_t lo, input int max_val);
        bcd_t      hi_max;
        bcd_t      lo_max;
        bcd_pair_t res;
        hi_max = bcd_t'(max_val / 10);
        lo_max = bcd_t'(max_val % 10);
        res    = '0;
        if ((hi > hi_max) || (lo > 4'd9) || ((hi == hi_max) && (lo > lo_max))) begin
            res = '0;
        end else if ((hi == hi_max) && (lo == lo_max)) begin
            res.carry = 1'b1;
        end else if (lo == 4'd9) begin
            res.hi = hi + 4'd1;
        end else begin
            res.hi = hi;
            res.lo = lo + 4'd1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : btn_debounce                                           |
// | Description : 2-flop synchronizer, stability counter and one-cycle   |
// |               press pulse on the debounced rising edge.              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int            CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // Synchronize, then accept a new level only after it has differed
    // from the accepted level for DEBOUNCE_CYC consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_press  <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/bcd_time_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bcd_time_counter                                       |
// | Description : Free-running 24-hour BCD timekeeper with prescaler,    |
// |               single-edge carry cascade and button time setting.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_mode,
    input  logic       btn_h,
    input  logic       btn_m,
    output logic [3:0] out_Hh,
    output logic [3:0] out_Hl,
    output logic [3:0] out_mh,
    output logic [3:0] out_ml,
    output logic [3:0] out_sh,
    output logic [3:0] out_sl,
    output logic       sec_tick,
    output logic       min_tick
);

    localparam int            PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] r_presc;
    bcd_t          r_hh, r_hl, r_mh, r_ml, r_sh, r_sl;
    logic          r_sec_tick;
    logic          r_min_tick;

    logic          w_press_h;
    logic          w_press_m;
    logic          w_tick;
    bcd_pair_t     w_sec_inc;
    bcd_pair_t     w_min_inc;
    logic [7:0]    w_hour_next;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_h (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_h),
        .press (w_press_h)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_m (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_m),
        .press (w_press_m)
    );

    // Set mode suppresses the tick, so a coincident set_mode rise drops it
    assign w_tick = !set_mode && (r_presc == PS_LAST);

    // Next value of each field, computed in parallel so the carry chain
    // resolves within a single edge
    always_comb begin
        w_sec_inc   = bcd_inc(r_sh, r_sl, SEC_MAX);
        w_min_inc   = bcd_inc(r_mh, r_ml, MIN_MAX);
        w_hour_next = 8'(bcd_inc(r_hh, r_hl, HOUR_MAX));
    end

    // Prescaler, time digits and tick pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_hh       <= '0;
            r_hl       <= '0;
            r_mh       <= '0;
            r_ml       <= '0;
            r_sh       <= '0;
            r_sl       <= '0;
            r_sec_tick <= 1'b0;
            r_min_tick <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            r_min_tick <= 1'b0;
            if (set_mode) begin
                // Paused: seconds held at 00, buttons edit fields with no carry
                r_presc <= '0;
                r_sh    <= '0;
                r_sl    <= '0;
                if (w_press_m) begin
                    r_mh       <= w_min_inc.hi;
                    r_ml       <= w_min_inc.lo;
                    r_min_tick <= 1'b1;
                end
                if (w_press_h) begin
                    {r_hh, r_hl} <= w_hour_next;
                end
            end else begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
                if (w_tick) begin
                    r_sh       <= w_sec_inc.hi;
                    r_sl       <= w_sec_inc.lo;
                    r_sec_tick <= 1'b1;
                    if (w_sec_inc.carry) begin
                        r_mh       <= w_min_inc.hi;
                        r_ml       <= w_min_inc.lo;
                        r_min_tick <= 1'b1;
                        if (w_min_inc.carry) begin
                            {r_hh, r_hl} <= w_hour_next;
                        end
                    end
                end
            end
        end
    end

    assign out_Hh   = r_hh;
    assign out_Hl   = r_hl;
    assign out_mh   = r_mh;
    assign out_ml   = r_ml;
    assign out_sh   = r_sh;
    assign out_sl   = r_sl;
    assign sec_tick = r_sec_tick;
    assign min_tick = r_min_tick;

endmodule
`default_nettype wire

// File: tb/tb_bcd_time_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_bcd_time_counter                                    |
// | Description : Directed self-checking bench for bcd_time_counter      |
// |               with CLK_HZ=4 and DEBOUNCE_CYC=3.                      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_bcd_time_counter;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        set_mode = 1'b0;
    logic        btn_h    = 1'b0;
    logic        btn_m    = 1'b0;
    logic [3:0]  out_Hh, out_Hl, out_mh, out_ml, out_sh, out_sl;
    logic        sec_tick;
    logic        min_tick;
    logic [23:0] now;

    int checks   = 0;
    int failures = 0;
    int ticks    = 0;

    always #5 clk = ~clk;

    bcd_time_counter #(.CLK_HZ(4), .DEBOUNCE_CYC(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_mode (set_mode),
        .btn_h    (btn_h),
        .btn_m    (btn_m),
        .out_Hh   (out_Hh),
        .out_Hl   (out_Hl),
        .out_mh   (out_mh),
        .out_ml   (out_ml),
        .out_sh   (out_sh),
        .out_sl   (out_sl),
        .sec_tick (sec_tick),
        .min_tick (min_tick)
    );

    assign now = {out_Hh, out_Hl, out_mh, out_ml, out_sh, out_sl};

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clean press: 6 cycles high, then 6 cycles low so the release settles
    task automatic press(input logic h, input logic m);
        btn_h = h;
        btn_m = m;
        repeat (6) @(negedge clk);
        btn_h = 1'b0;
        btn_m = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_time", now, 24'h000000);
        chk("reset_sec_tick", {23'd0, sec_tick}, 24'd0);
        chk("reset_min_tick", {23'd0, min_tick}, 24'd0);

        // First second after reset: 4 cycles, one sec_tick pulse
        rst_n = 1'b1;
        ticks = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 3) chk("before_first_tick", now, 24'h000000);
            if (i == 4) begin
                chk("first_second", now, 24'h000001);
                chk("first_sec_tick", {23'd0, sec_tick}, 24'd1);
            end
            ticks += int'(sec_tick);
        end
        chk("sec_tick_count", 24'(ticks), 24'd1);

        // Preload 23:59 in set mode, then run up to 23:59:58
        set_mode = 1'b1;
        for (int i = 0; i < 23; i++) press(1'b1, 1'b1);
        for (int i = 0; i < 36; i++) press(1'b0, 1'b1);
        chk("preload_23_59", now, 24'h235900);
        set_mode = 1'b0;
        repeat (232) @(negedge clk);
        chk("run_to_235958", now, 24'h235958);
        repeat (3) @(negedge clk);
        chk("no_tick_mid_second", {23'd0, sec_tick}, 24'd0);
        @(negedge clk);
        chk("time_235959", now, 24'h235959);
        chk("sec_tick_235959", {23'd0, sec_tick}, 24'd1);
        chk("no_min_tick_235959", {23'd0, min_tick}, 24'd0);
        repeat (4) @(negedge clk);
        chk("day_wrap", now, 24'h000000);
        chk("wrap_sec_tick", {23'd0, sec_tick}, 24'd1);
        chk("wrap_min_tick", {23'd0, min_tick}, 24'd1);

        // Set 12:34, run to 12:34:56, enter set mode
        set_mode = 1'b1;
        for (int i = 0; i < 12; i++) press(1'b1, 1'b1);
        for (int i = 0; i < 22; i++) press(1'b0, 1'b1);
        set_mode = 1'b0;
        repeat (224) @(negedge clk);
        chk("time_123456", now, 24'h123456);
        set_mode = 1'b1;
        @(negedge clk);
        chk("set_clears_seconds", now, 24'h123400);

        // Clean btn_m press: digit change on the 6th edge after the raw edge
        btn_m = 1'b1;
        repeat (5) @(negedge clk);
        chk("btn_m_latency_hold", now, 24'h123400);
        @(negedge clk);
        chk("btn_m_press", now, 24'h123500);
        chk("btn_m_min_tick", {23'd0, min_tick}, 24'd1);
        btn_m = 1'b0;
        @(negedge clk);
        chk("min_tick_one_cycle", {23'd0, min_tick}, 24'd0);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 24; i++) press(1'b0, 1'b1);
        chk("minutes_59", now, 24'h125900);
        press(1'b0, 1'b1);
        chk("minutes_wrap_no_carry", now, 24'h120000);

        // Bouncing btn_h at 23:00
        for (int i = 0; i < 11; i++) press(1'b1, 1'b0);
        chk("hours_23", now, 24'h230000);
        for (int i = 0; i < 2; i++) begin
            btn_h = 1'b1;
            repeat (2) @(negedge clk);
            btn_h = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("bounce_no_press", now, 24'h230000);
        btn_h = 1'b1;
        repeat (5) @(negedge clk);
        btn_h = 1'b0;
        repeat (8) @(negedge clk);
        chk("hour_wrap_single_press", now, 24'h000000);

        // Simultaneous presses at 09:59
        for (int i = 0; i < 9; i++) press(1'b1, 1'b1);
        for (int i = 0; i < 50; i++) press(1'b0, 1'b1);
        chk("time_0959", now, 24'h095900);
        btn_h = 1'b1;
        btn_m = 1'b1;
        repeat (5) @(negedge clk);
        chk("both_latency_hold", now, 24'h095900);
        @(negedge clk);
        chk("both_same_edge", now, 24'h100000);
        btn_h = 1'b0;
        btn_m = 1'b0;
        repeat (6) @(negedge clk);

        // Asynchronous reset mid-prescale at 17:45:30
        for (int i = 0; i < 7; i++) press(1'b1, 1'b1);
        for (int i = 0; i < 38; i++) press(1'b0, 1'b1);
        chk("time_1745", now, 24'h174500);
        set_mode = 1'b0;
        repeat (120) @(negedge clk);
        chk("time_174530", now, 24'h174530);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_time", now, 24'h000000);
        @(negedge clk);
        rst_n = 1'b1;
        ticks = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 4) chk("post_reset_first_sec", now, 24'h000001);
            ticks += int'(sec_tick) * i;
        end
        chk("post_reset_tick_cycle", 24'(ticks), 24'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
